// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle for the bit-serial add/subtract controller.
// The requester drives the master side; the controller sits on the slave side.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, op_a, op_b,
        input  result, cout, overflow, busy, done
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output result, cout, overflow, busy, done
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full adder stepped over WIDTH bits,
// LSB first, returning result, carry-out and signed overflow with a done pulse.
module FullAdder_1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_add_ctrl_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] r_next;

    FullAdder_1 u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits enter at the MSB so bit i lands at position i after WIDTH shifts.
    assign r_next = {fa_sum, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract folds into the add: the sub flag lives on as
                        // the inverted B operand and the initial carry.
                        a_sr   <= bus.op_a;
                        b_sr   <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry  <= bus.sub;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= r_next;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result_q   <= r_next;
                        cout_q     <= fa_cout;
                        overflow_q <= carry ^ fa_cout;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
